// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared types and op-decoding helpers for the EX-stage multiply/divide unit.
//   muldiv_op_e : operation select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   state_e     : control FSM states
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return (op inside {DIV, DIVU, REM, REMU});
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op inside {MULH, MULHSU, DIV, REM});
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op inside {MULH, DIV, REM});
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
//   One radix-2 iteration of the shared multiply/divide datapath, combinational.
//   The {hi, lo} pair is the 2*XLEN working register:
//     multiply : hi = partial product upper half, lo = multiplier shifting out / product low half
//     divide   : hi = partial remainder,          lo = dividend shifting out / quotient shifting in
// Ports
//   is_div  in   1     select compare-subtract-shift (1) or add-shift (0)
//   opb     in   XLEN  multiplicand or divisor magnitude
//   hi_in   in   XLEN  working register upper half
//   lo_in   in   XLEN  working register lower half
//   hi_out  out  XLEN  updated upper half
//   lo_out  out  XLEN  updated lower half
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] opb,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        shifted = {hi_in, lo_in[XLEN-1]};
        // When ge holds the true difference is below opb, so XLEN bits suffice.
        diff    = shifted[XLEN-1:0] - opb;
        ge      = (shifted >= {1'b0, opb});

        if (is_div) begin
            hi_out = ge ? diff : shifted[XLEN-1:0];
            lo_out = {lo_in[XLEN-2:0], ge};
        end else begin
            hi_out = sum[XLEN:1];
            lo_out = {sum[0], lo_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply/divide unit beside the EX-stage ALU. Operands are reduced to
//   magnitudes at start, iterated BITS_PER_CYCLE bits per clock, and sign-corrected
//   (or overridden for divide-by-zero / signed overflow) in the FIX state.
//   Latency from accepted start to done is always N+2 clocks, N = XLEN/BITS_PER_CYCLE.
// Ports
//   clk     in   1     clock
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     request, sampled only in IDLE
//   op      in   3     muldiv_op_e
//   srca    in   XLEN  multiplicand / dividend
//   srcb    in   XLEN  multiplier / divisor
//   flush   in   1     synchronous abort
//   busy    out  1     high in CALC and FIX
//   done    out  1     one-cycle result-valid pulse
//   result  out  XLEN  last completed result
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// CALC  | N iterations, BITS_PER_CYCLE bits each
// FIX   | sign correction / special-case override, result written
// DONE  | done pulse; start ignored
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(N - 1);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic              load, step, write;

    muldiv_op_e        op_in, op_q;
    logic [CNT_W-1:0]  count_q;
    logic [XLEN-1:0]   hi_q, lo_q, opb_q;
    logic              neg_res_q;
    logic              spec_en_q;
    logic [XLEN-1:0]   spec_val_q;
    logic [XLEN-1:0]   result_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        write   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // flush wins over a same-cycle start
                if (!flush && start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (count_q == LAST) state_d = FIX;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    write   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

    // ------------------------------------------------------ operand decode
    logic            a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] spec_val_in;
    logic            neg_res_in;

    assign op_in = muldiv_op_e'(op);

    always_comb begin
        a_neg    = is_signed_a(op_in) & srca[XLEN-1];
        b_neg    = is_signed_b(op_in) & srcb[XLEN-1];
        mag_a    = a_neg ? (~srca + 1'b1) : srca;
        mag_b    = b_neg ? (~srcb + 1'b1) : srcb;
        div_zero = is_div(op_in) && (srcb == '0);
        div_ovf  = (op_in == DIV || op_in == REM) && (srca == MIN_NEG) && (srcb == '1);

        spec_val_in = '0;
        if (div_zero)
            spec_val_in = (op_in == DIV || op_in == DIVU) ? '1 : srca;
        else if (div_ovf)
            spec_val_in = (op_in == DIV) ? srca : '0;

        // remainder follows the dividend; product and quotient follow sign XOR
        if (op_in == REM || op_in == REMU) neg_res_in = a_neg;
        else                               neg_res_in = a_neg ^ b_neg;
    end

    // ------------------------------------------------------- step chain
    logic [XLEN-1:0] hi_chain [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] lo_chain [BITS_PER_CYCLE+1];
    logic            div_mode;

    assign div_mode    = is_div(op_q);
    assign hi_chain[0] = hi_q;
    assign lo_chain[0] = lo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div (div_mode),
            .opb    (opb_q),
            .hi_in  (hi_chain[i]),
            .lo_in  (lo_chain[i]),
            .hi_out (hi_chain[i+1]),
            .lo_out (lo_chain[i+1])
        );
    end

    // ------------------------------------------------------- fix-up
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_res_q ? (~prod + 1'b1) : prod;
        fix_val  = '0;
        unique case (op_q)
            MUL:                fix_val = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:          fix_val = neg_res_q ? (~lo_q + 1'b1) : lo_q;
            REM, REMU:          fix_val = neg_res_q ? (~hi_q + 1'b1) : hi_q;
            default:            fix_val = '0;
        endcase
        if (spec_en_q) fix_val = spec_val_q;
    end

    // ------------------------------------------------------- datapath regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= MUL;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            neg_res_q  <= 1'b0;
            spec_en_q  <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
        end else begin
            if (load) begin
                op_q       <= op_in;
                count_q    <= '0;
                hi_q       <= '0;
                lo_q       <= mag_a;
                opb_q      <= mag_b;
                neg_res_q  <= neg_res_in;
                spec_en_q  <= div_zero | div_ovf;
                spec_val_q <= spec_val_in;
            end else if (step) begin
                hi_q    <= hi_chain[BITS_PER_CYCLE];
                lo_q    <= lo_chain[BITS_PER_CYCLE];
                count_q <= count_q + 1'b1;
            end
            if (write) result_q <= fix_val;
        end
    end

endmodule
